freq_meter_count: RTL

- Sits directly downstream of the gate generator in the frequency counter.
- Counts rising edges of the asynchronous signal under test while gate is high.
- On each gate falling edge, latches the edge count, scales it to Hz, and pulses a one-cycle valid strobe for the display/readout stage.
- Results hold until the next complete gate window finishes.

---
 rtl/freq_meter_count.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/freq_meter_count.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_count
// Description : Counts rising edges of an asynchronous signal while the gate
//               from the gate generator is high. When the gate falls, the
//               edge count is latched, scaled to Hz and announced with a
//               one-cycle valid strobe. Results hold until the next complete
//               gate window finishes.
// Ports       : clock       - system clock (gate generator domain)
//               rst_n       - asynchronous active-low reset
//               gate        - measurement window, synchronous to clock
//               sig_in      - signal under test, asynchronous to clock
//               count       - edges counted in the last completed window
//               freq_hz     - count * SCALE for the last completed window
//               overflow    - last completed window saturated the counter
//               count_valid - one-cycle pulse after the results update
//               measuring   - high while a window is being counted
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter_count #(
  parameter int CNT_W  = 16,
  parameter int SCALE  = 2000,
  parameter int FREQ_W = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              gate,
  input  logic              sig_in,
  output logic [CNT_W-1:0]  count,
  output logic [FREQ_W-1:0] freq_hz,
  output logic              overflow,
  output logic              count_valid,
  output logic              measuring
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;
  localparam logic [FREQ_W-1:0] c_SCALE   = FREQ_W'(SCALE);

  // Input conditioning
  logic r_s1, r_s2, r_s3;
  logic r_gate_q;
  // Set once gate has been seen low after reset, so a gate that is already
  // high when reset is released never opens a window.
  logic r_armed;

  logic w_sig_rise;
  logic w_gate_rise;
  logic w_gate_fall;

  // FSM
  state_t r_state;
  state_t w_state_nxt;
  logic   w_cnt_clr;
  logic   w_cnt_inc;
  logic   w_capture;
  logic   w_latch;

  // Datapath
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_count;
  logic [FREQ_W-1:0] r_freq;
  logic              r_overflow;
  logic              r_valid;
  logic              r_measuring;
  logic [FREQ_W-1:0] w_freq;

  // --------------------------------------------------------------------------
  // Synchronizer and edge detection
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_gate_q <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_s1     <= sig_in;
      r_s2     <= r_s1;
      r_s3     <= r_s2;
      r_gate_q <= gate;
      r_armed  <= r_armed | ~gate;
    end
  end

  assign w_sig_rise  = r_s2 & ~r_s3;
  assign w_gate_rise = gate & ~r_gate_q & r_armed;
  assign w_gate_fall = ~gate & r_gate_q;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_capture   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // An edge in the gate_rise cycle is dropped: the clear wins.
        if (w_gate_rise) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        // An edge in the gate_fall cycle is dropped: the capture wins.
        if (w_gate_fall) begin
          w_capture   = 1'b1;
          w_state_nxt = S_LATCH;
        end else if (w_sig_rise) begin
          w_cnt_inc = 1'b1;
        end
      end
      S_LATCH: begin
        w_latch = 1'b1;
        // A one-cycle-low gate starts the next window straight from here.
        if (w_gate_rise) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_COUNT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Edge counter, result registers and strobes
  // --------------------------------------------------------------------------
  assign w_freq = FREQ_W'(r_count) * c_SCALE;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_freq      <= '0;
      r_overflow  <= 1'b0;
      r_valid     <= 1'b0;
      r_measuring <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_cnt_inc) begin
        // The counter sticks at all-ones; an edge arriving while it is
        // saturated is an edge that was lost, so flag the overflow.
        if (r_cnt == c_CNT_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      if (w_capture) begin
        r_count    <= r_cnt;
        r_overflow <= r_ovf;
      end

      // freq_hz follows count by one cycle; the strobe lines up with it.
      if (w_latch) begin
        r_freq <= w_freq;
      end
      r_valid     <= w_latch;
      r_measuring <= (w_state_nxt == S_COUNT);
    end
  end

  assign count       = r_count;
  assign freq_hz     = r_freq;
  assign overflow    = r_overflow;
  assign count_valid = r_valid;
  assign measuring   = r_measuring;

endmodule
`default_nettype wire
